mcu_refclk_ctrl: RTL and testbench
==================================

Name: mcu_refclk_ctrl

Overview:
- Sequences the reference clock sent to the microcontroller.
- Drives the din0/din1 inputs of a 1-bit DDR output buffer clocked on both edges of clk_50mhz. din0 is the rising-edge half-slot and din1 the falling-edge half-slot.
- Supports run/stop and a programmable divide ratio with 50% duty at half-cycle resolution.
- All configuration changes are applied only on period boundaries, so the MCU never sees a runt pulse.

Parameters:
- DIV_WIDTH, 8, width of the divide-ratio field. Output period = N cycles of clk_50mhz.
- COUNT_WIDTH, 16, width of the completed-period counter.

Ports:
- clk_50mhz  in  1  system clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-high
- cfg_update  in  1  one-cycle strobe; samples cfg_en and cfg_div
- cfg_en  in  1  1 = clock output running, 0 = output parked low
- cfg_div  in  DIV_WIDTH  divide ratio N; 0 is treated as 1
- cfg_busy  out  1  a sampled config is pending, not yet applied
- cfg_ack  out  1  one-cycle pulse on the cycle the new config first drives din0/din1
- running  out  1  output currently toggling
- din0  out  1  DDR rising-edge half-slot data
- din1  out  1  DDR falling-edge half-slot data
- period_count  out  COUNT_WIDTH  completed output periods, wrapping

Behaviour:
- Reset (async assert, sync-safe deassert): din0=din1=0, running=0, cfg_busy=0, cfg_ack=0, period_count=0, phase p=0, active N=1, shadow cleared.
- Waveform definition:
  - A period of N cycles is 2N half-slots, s=0..2N-1; slot value = (s >= N).
  - In phase p (0..N-1): din0 = slot 2p, din1 = slot 2p+1.
  - N=1 gives din0=0, din1=1, i.e. 50 MHz passthrough.
- Outputs are registered. The value on din0/din1 during a cycle is the pair for the phase held in the register.
- State machine, STOPPED / RUNNING:
  - STOPPED: din0=din1=0, running=0.
  - RUNNING: p increments each cycle and wraps N-1 -> 0. period_count increments (mod 2^COUNT_WIDTH) on every wrap.
- Shadow register:
  - cfg_update loads {cfg_en, max(cfg_div,1)} into the shadow and sets cfg_busy at the next edge.
  - A further cfg_update while busy overwrites the shadow. Only the last value is applied, with exactly one cfg_ack.
- Apply point, STOPPED: the edge after the shadow is loaded.
  - If shadow en=1: enter RUNNING with p=0. The first pair for new N is registered; cfg_ack=1 and running=1 that cycle.
  - If shadow en=0: stay STOPPED; still pulse cfg_ack.
  - Latency from cfg_update to cfg_ack is 2 cycles.
- Apply point, RUNNING: the edge at which p would wrap (current pair is phase N-1).
  - en=1: load the new N and restart at p=0.
  - en=0: go to STOPPED and output 0/0.
  - The wrap is counted in period_count in both cases. cfg_ack pulses on that edge; cfg_busy clears on that edge.
- cfg_update on the same cycle as an apply edge: the applied value is the one already in the shadow. The new sample loads the shadow and busy stays 1.
- Reapplying identical config (same N, en=1) still takes effect at the boundary, with no visible discontinuity, and produces cfg_ack.
- Reset mid-period forces 0/0 immediately (async) and discards any pending config.

Test Plan:
- Reset, then cfg_update en=1 div=1 -> cfg_ack 2 cycles later; thereafter din0=0, din1=1 every cycle; running=1; period_count +1 per cycle.
- Running N=1, update div=3 -> applied at next boundary; pairs repeat (0,0),(0,1),(1,1); period_count +1 every 3 cycles.
- Running N=3 at p=0, update en=0 -> outputs (0,1),(1,1), then 0/0; cfg_ack on the 0/0 edge; running=0; cfg_busy high for exactly those cycles.
- Running N=4, three cfg_update strobes with div=2, 5, 2 before the boundary -> single cfg_ack; new pattern (0,0),(1,1); no partial period.
- cfg_div=0 with en=1 from STOPPED -> behaves as N=1: (0,1) each cycle.
- Assert rst mid-period with an update pending -> din0=din1=0 asynchronously; busy/ack/running/period_count all 0; no ack after release.

Source files
------------

// File: rtl/mcu_refclk_ctrl.sv
// Reference-clock sequencer for the MCU: drives DDR din0/din1 half-slots with a programmable
// 50%-duty divide ratio, run/stop control, and config changes applied only at period boundaries.
module mcu_refclk_ctrl #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk_50mhz,
  input  logic                   rst,
  input  logic                   cfg_update,
  input  logic                   cfg_en,
  input  logic [DIV_WIDTH-1:0]   cfg_div,
  output logic                   cfg_busy,
  output logic                   cfg_ack,
  output logic                   running,
  output logic                   din0,
  output logic                   din1,
  output logic [COUNT_WIDTH-1:0] period_count
);

  typedef enum logic [0:0] {StStopped, StRunning} state_e;

  localparam logic [DIV_WIDTH-1:0] DivOne = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q;
  logic [DIV_WIDTH-1:0]   p_q, n_q, sh_div_q;
  logic                   sh_en_q, busy_q, ack_q, run_q, din0_q, din1_q;
  logic [COUNT_WIDTH-1:0] count_q;

  logic                   wrap, apply;
  logic [DIV_WIDTH-1:0]   div_eff, p_inc, n_restart;
  logic [DIV_WIDTH:0]     slot0, slot1;
  logic                   inc_din0, inc_din1, rst_din1;

  always_comb begin
    div_eff   = (cfg_div == '0) ? DivOne : cfg_div;
    wrap      = (state_q == StRunning) && (p_q == n_q - DivOne);
    apply     = busy_q && ((state_q == StStopped) || wrap);
    n_restart = apply ? sh_div_q : n_q;
    p_inc     = p_q + DivOne;
    // Half-slots 2p and 2p+1 are high once they reach N.
    slot0     = {p_inc, 1'b0};
    slot1     = {p_inc, 1'b1};
    inc_din0  = slot0 >= {1'b0, n_q};
    inc_din1  = slot1 >= {1'b0, n_q};
    // Phase 0 is always (0, N==1).
    rst_din1  = (n_restart == DivOne);
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state_q  <= StStopped;
      p_q      <= '0;
      n_q      <= DivOne;
      sh_div_q <= '0;
      sh_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      run_q    <= 1'b0;
      din0_q   <= 1'b0;
      din1_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      ack_q <= apply;
      // A new sample on an apply edge wins the shadow; the old one is what gets applied.
      if (cfg_update) begin
        sh_en_q  <= cfg_en;
        sh_div_q <= div_eff;
        busy_q   <= 1'b1;
      end else if (apply) begin
        busy_q <= 1'b0;
      end

      unique case (state_q)
        StStopped: begin
          if (apply && sh_en_q) begin
            state_q <= StRunning;
            n_q     <= sh_div_q;
            p_q     <= '0;
            din0_q  <= 1'b0;
            din1_q  <= (sh_div_q == DivOne);
            run_q   <= 1'b1;
          end
        end
        StRunning: begin
          if (wrap) begin
            count_q <= count_q + 1'b1;
            p_q     <= '0;
            if (apply && !sh_en_q) begin
              state_q <= StStopped;
              din0_q  <= 1'b0;
              din1_q  <= 1'b0;
              run_q   <= 1'b0;
            end else begin
              n_q    <= n_restart;
              din0_q <= 1'b0;
              din1_q <= rst_din1;
            end
          end else begin
            p_q    <= p_inc;
            din0_q <= inc_din0;
            din1_q <= inc_din1;
          end
        end
        default: state_q <= StStopped;
      endcase
    end
  end

  assign cfg_busy     = busy_q;
  assign cfg_ack      = ack_q;
  assign running      = run_q;
  assign din0         = din0_q;
  assign din1         = din1_q;
  assign period_count = count_q;

endmodule

// File: tb/tb_mcu_refclk_ctrl.sv
// Randomized self-checking bench for mcu_refclk_ctrl against a cycle-level behavioural model
// built from the half-slot waveform rule (slot s high when s >= N).
module tb_mcu_refclk_ctrl;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk_50mhz = 1'b0;
  logic          rst;
  logic          cfg_update, cfg_en;
  logic [DW-1:0] cfg_div;
  logic          cfg_busy, cfg_ack, running, din0, din1;
  logic [CW-1:0] period_count;

  mcu_refclk_ctrl #(.DIV_WIDTH(DW), .COUNT_WIDTH(CW)) u_dut (
    .clk_50mhz   (clk_50mhz),
    .rst         (rst),
    .cfg_update  (cfg_update),
    .cfg_en      (cfg_en),
    .cfg_div     (cfg_div),
    .cfg_busy    (cfg_busy),
    .cfg_ack     (cfg_ack),
    .running     (running),
    .din0        (din0),
    .din1        (din1),
    .period_count(period_count)
  );

  always #5 clk_50mhz = ~clk_50mhz;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: integers, phase counted within the active period.
  bit m_run, m_busy, m_ack, m_sh_en;
  int m_n, m_ph, m_cnt, m_sh_n;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_busy = 0; m_ack = 0; m_sh_en = 0;
    m_n = 1; m_ph = 0; m_cnt = 0; m_sh_n = 1;
  endtask

  // One clock edge with the inputs currently on the pins.
  task automatic model_step(input bit upd, input bit en, input int div);
    bit at_end, take;
    at_end = m_run && (m_ph == m_n - 1);
    take   = m_busy && (!m_run || at_end);
    m_ack  = take;
    if (at_end) m_cnt = (m_cnt + 1) % (1 << CW);
    if (m_run) m_ph = at_end ? 0 : m_ph + 1;
    if (take) begin
      m_run = m_sh_en;
      m_ph  = 0;
      if (m_sh_en) m_n = m_sh_n;
    end
    if (upd) begin
      m_sh_en = en;
      m_sh_n  = (div == 0) ? 1 : div;
      m_busy  = 1;
    end else if (take) begin
      m_busy = 0;
    end
  endtask

  task automatic check_all();
    check_eq("din0",    32'(din0),         32'(m_run && (2 * m_ph >= m_n)));
    check_eq("din1",    32'(din1),         32'(m_run && (2 * m_ph + 1 >= m_n)));
    check_eq("running", 32'(running),      32'(m_run));
    check_eq("busy",    32'(cfg_busy),     32'(m_busy));
    check_eq("ack",     32'(cfg_ack),      32'(m_ack));
    check_eq("count",   32'(period_count), 32'(m_cnt));
  endtask

  task automatic tick();
    @(posedge clk_50mhz);
    model_step(cfg_update, cfg_en, int'(cfg_div));
    #1;
    check_all();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_upd(input bit en, input int div);
    cfg_update = 1'b1;
    cfg_en     = en;
    cfg_div    = DW'(div);
    tick();
    cfg_update = 1'b0;
  endtask

  // Async reset between edges: outputs must drop without a clock edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_update = 1'b0; cfg_en = 1'b0; cfg_div = '0;
    model_reset();
    #12;
    check_all();
    rst = 1'b0;
    run_cycles(2);

    do_upd(1'b1, 1);  run_cycles(5);
    do_upd(1'b1, 3);  run_cycles(9);
    do_upd(1'b0, 0);  run_cycles(5);
    do_upd(1'b1, 4);  run_cycles(3);
    do_upd(1'b1, 2);  do_upd(1'b1, 5);  do_upd(1'b1, 2);  run_cycles(8);
    do_upd(1'b0, 7);  run_cycles(4);
    do_upd(1'b1, 0);  run_cycles(5);
    do_upd(1'b1, 0);  run_cycles(3);

    do_upd(1'b1, 6);  run_cycles(8);
    do_upd(1'b0, 0);
    pulse_reset();
    run_cycles(6);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        cfg_update = 1'b1;
        cfg_en     = ($urandom_range(0, 3) != 0);
        cfg_div    = ($urandom_range(0, 15) == 0) ? DW'($urandom_range(0, 255))
                                                   : DW'($urandom_range(0, 6));
      end else begin
        cfg_update = 1'b0;
      end
      tick();
      if (i == 1500) pulse_reset();
    end
    cfg_update = 1'b0;
    run_cycles(4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
